hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage ARM core. It consumes the EX-stage control outputs of the ID/EX pipeline register, plus the register operands of the instruction in ID, and generates the stall, bubble, flush and hold controls that gate PC, IF/ID and ID/EX. It sequences load-use stalls, taken-branch flushes and data-memory wait states through a small state machine, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- `FLUSH_CYCLES`, default 1: extra cycles of IF/ID flush after a taken branch (1..3).
- `CNT_W`, default 16: width of the stall counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `id_rn` in 4: first source register of the ID instruction.
- `id_rm` in 4: second source register of the ID instruction.
- `id_rn_used` in 1: `id_rn` is actually read.
- `id_rm_used` in 1: `id_rm` is actually read.
- `ex_rd` in 4: destination register of the EX instruction.
- `ex_reg_write_enable` in 1: EX instruction writes `ex_rd`.
- `ex_mem_to_reg_select` in 1: EX instruction is a load.
- `ex_branch_taken` in 1: branch resolved taken in EX this cycle.
- `mem_busy` in 1: data memory not ready; the whole pipe must freeze.
- `pc_write_enable` out 1: PC may update.
- `if_id_write_enable` out 1: IF/ID may load.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `id_ex_bubble` out 1: ID/EX loads all-zero control signals.
- `id_ex_hold` out 1: ID/EX keeps its current contents.
- `stall_count` out CNT_W: saturating count of cycles with `pc_write_enable`=0.

## Operation
- `load_use` = `ex_mem_to_reg_select` & `ex_reg_write_enable` & ((`id_rn_used` & `id_rn`==`ex_rd`) | (`id_rm_used` & `id_rm`==`ex_rd`)).
- States: RUN, LOAD_STALL, FLUSH, MEM_WAIT. Event priority in every state: `mem_busy` > `ex_branch_taken` > `load_use`.
- RUN:
  - Default outputs: PC=1, IF/ID write=1, all others 0.
  - On `mem_busy`: PC=0, IF/ID write=0, hold=1; go to MEM_WAIT.
  - On `ex_branch_taken`: `if_id_flush`=1, bubble=1, PC=1; load the flush counter with FLUSH_CYCLES-1. If that value is 0, stay in RUN; otherwise go to FLUSH.
  - On `load_use`: PC=0, IF/ID write=0, bubble=1; go to LOAD_STALL.
- LOAD_STALL lasts exactly one cycle.
  - Outputs as RUN defaults, with `load_use` detection masked.
  - Next state is RUN. If `mem_busy` is high, MEM_WAIT takes priority.
- FLUSH:
  - Outputs: `if_id_flush`=1, bubble=1, PC=1.
  - Decrement the counter and return to RUN when it reaches 0.
  - A new `ex_branch_taken` reloads the counter.
  - `mem_busy` preempts: go to MEM_WAIT and discard the remaining flush.
- MEM_WAIT:
  - Outputs: PC=0, IF/ID write=0, hold=1, bubble=0, flush=0.
  - Return to RUN in the first cycle `mem_busy`=0. That cycle is evaluated as RUN, combinationally.
- `stall_count` increments each cycle `pc_write_enable`=0 and saturates at all-ones. It never wraps.
- Register r15 is matched like any other register. There is no special case.

## Timing
- Outputs are Mealy: state plus same-cycle inputs, with no added latency. The ID/EX and IF/ID registers sample them on the same `clk` edge.
- A load-use hazard costs exactly 1 stall cycle. A taken branch costs 2 + (FLUSH_CYCLES-1) squashed slots.
- Asserting `reset` (low) immediately, without waiting for a clock edge:
  - state=RUN, counter=0, `stall_count`=0.
  - Outputs forced to PC=0, IF/ID write=0, bubble=1, flush=0, hold=0.
- Deasserting `reset`: RUN behaviour starts on the next cycle.
- `reset` asserted mid-stall or mid-flush aborts the sequence with no residue.
- `id_ex_hold` and `id_ex_bubble` are never both 1.
- `pc_write_enable`=1 whenever `if_id_flush`=1.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - State enum `hz_state_t` (RUN, LOAD_STALL, FLUSH, MEM_WAIT).
  - Register-index width constant `REG_IDX_W`=4.
  - NOP encoding used by IF/ID flush.
- One natural sub-module, `sat_counter`: parameterised width, increment enable, asynchronous active-low clear. Used for `stall_count`.

## Test plan
- LDR r3 in EX (`ex_rd`=3, load=1, write=1), ID reads `id_rm`=3 with `id_rm_used`=1 -> 1 cycle of PC=0 and bubble=1, then RUN; `stall_count`=1.
- Same as above but `id_rm_used`=0 -> no stall, `stall_count` stays 0.
- `ex_branch_taken` pulse with FLUSH_CYCLES=3 -> flush=1 for 3 consecutive cycles and PC=1 throughout.
- `mem_busy` high for 4 cycles, with `load_use` and `ex_branch_taken` also asserted in cycle 1 -> hold=1 for 4 cycles, no flush or bubble during them; the branch is ignored unless still asserted when `mem_busy` falls; `stall_count`=4.
- Preload `stall_count` to 0xFFFE, then 3 stall cycles -> saturates at 0xFFFF.
- `reset` pulled low in the second cycle of FLUSH -> outputs immediately take reset values; after release, RUN with flush=0.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, register index width,
// IF/ID flush NOP encoding and the source/destination match helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  localparam int REG_IDX_W = 4;

  // Flush counter only needs to hold FLUSH_CYCLES-1, at most 2.
  localparam int FLUSH_CNT_W = 2;

  // MOV r0, r0 (ARM, always-execute condition).
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  function automatic logic src_hit(input logic                 used,
                                   input logic [REG_IDX_W-1:0] src,
                                   input logic [REG_IDX_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with an asynchronous active-low clear; it stops at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, holding at the all-ones ceiling.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: Mealy decode of load-use, taken-branch and
// data-memory wait events into PC / IF/ID / ID/EX gating, plus a stall counter.
module hazard_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic                 id_rn_used,
  input  logic                 id_rm_used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_reg_write_enable,
  input  logic                 ex_mem_to_reg_select,
  input  logic                 ex_branch_taken,
  input  logic                 mem_busy,
  output logic                 pc_write_enable,
  output logic                 if_id_write_enable,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 id_ex_hold,
  output logic [CNT_W-1:0]     stall_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_t              state_r;
  hz_state_t              state_nxt_s;
  logic [FLUSH_CNT_W-1:0] flush_cnt_r;
  logic [FLUSH_CNT_W-1:0] flush_cnt_nxt_s;

  logic load_use_s;
  logic eval_run_s;
  logic lu_enable_s;
  logic pc_we_s;
  logic if_id_we_s;
  logic flush_s;
  logic bubble_s;
  logic hold_s;

  assign load_use_s = ex_mem_to_reg_select && ex_reg_write_enable &&
                      (src_hit(id_rn_used, id_rn, ex_rd) ||
                       src_hit(id_rm_used, id_rm, ex_rd));

  // Next-state and Mealy output decode; RUN evaluation is shared by the states
  // that fall back to normal behaviour in the same cycle.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    pc_we_s         = 1'b1;
    if_id_we_s      = 1'b1;
    flush_s         = 1'b0;
    bubble_s        = 1'b0;
    hold_s          = 1'b0;
    eval_run_s      = 1'b0;
    lu_enable_s     = 1'b1;

    case (state_r)
      RUN: begin
        eval_run_s = 1'b1;
      end
      LOAD_STALL: begin
        eval_run_s  = 1'b1;
        lu_enable_s = 1'b0;
      end
      FLUSH: begin
        if (mem_busy) begin
          pc_we_s         = 1'b0;
          if_id_we_s      = 1'b0;
          hold_s          = 1'b1;
          flush_cnt_nxt_s = '0;
          state_nxt_s     = MEM_WAIT;
        end else if (ex_branch_taken) begin
          flush_s         = 1'b1;
          bubble_s        = 1'b1;
          flush_cnt_nxt_s = FLUSH_LOAD;
          state_nxt_s     = (FLUSH_LOAD == '0) ? RUN : FLUSH;
        end else if (flush_cnt_r <= FLUSH_CNT_W'(1)) begin
          flush_s         = 1'b1;
          bubble_s        = 1'b1;
          flush_cnt_nxt_s = '0;
          state_nxt_s     = RUN;
        end else begin
          flush_s         = 1'b1;
          bubble_s        = 1'b1;
          flush_cnt_nxt_s = flush_cnt_r - FLUSH_CNT_W'(1);
          state_nxt_s     = FLUSH;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          pc_we_s     = 1'b0;
          if_id_we_s  = 1'b0;
          hold_s      = 1'b1;
          state_nxt_s = MEM_WAIT;
        end else begin
          eval_run_s = 1'b1;
        end
      end
      default: begin
        eval_run_s = 1'b1;
      end
    endcase

    if (eval_run_s) begin
      if (mem_busy) begin
        pc_we_s     = 1'b0;
        if_id_we_s  = 1'b0;
        hold_s      = 1'b1;
        state_nxt_s = MEM_WAIT;
      end else if (ex_branch_taken) begin
        flush_s         = 1'b1;
        bubble_s        = 1'b1;
        flush_cnt_nxt_s = FLUSH_LOAD;
        state_nxt_s     = (FLUSH_LOAD == '0) ? RUN : FLUSH;
      end else if (lu_enable_s && load_use_s) begin
        pc_we_s     = 1'b0;
        if_id_we_s  = 1'b0;
        bubble_s    = 1'b1;
        state_nxt_s = LOAD_STALL;
      end else begin
        state_nxt_s = RUN;
      end
    end else begin
      lu_enable_s = 1'b1;
    end
  end

  // Reset overrides the decoded controls immediately, without a clock edge.
  always_comb begin
    if (!reset) begin
      pc_write_enable    = 1'b0;
      if_id_write_enable = 1'b0;
      if_id_flush        = 1'b0;
      id_ex_bubble       = 1'b1;
      id_ex_hold         = 1'b0;
    end else begin
      pc_write_enable    = pc_we_s;
      if_id_write_enable = if_id_we_s;
      if_id_flush        = flush_s;
      id_ex_bubble       = bubble_s;
      id_ex_hold         = hold_s;
    end
  end

  // Hazard FSM state and remaining-flush counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      flush_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .clear_n (reset),
    .en      (~pc_write_enable),
    .count   (stall_count)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a RUN-state decode table plus
// multi-cycle sequences (load-use, flush, memory wait, saturation, reset).
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, ex_rd;
  logic       id_rn_used, id_rm_used;
  logic       ex_reg_write_enable, ex_mem_to_reg_select, ex_branch_taken, mem_busy;

  logic        pc_a, ifid_a, flush_a, bubble_a, hold_a;
  logic [15:0] cnt_a;
  logic        pc_b, ifid_b, flush_b, bubble_b, hold_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.FLUSH_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .ex_rd(ex_rd), .ex_reg_write_enable(ex_reg_write_enable),
    .ex_mem_to_reg_select(ex_mem_to_reg_select), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .pc_write_enable(pc_a), .if_id_write_enable(ifid_a), .if_id_flush(flush_a),
    .id_ex_bubble(bubble_a), .id_ex_hold(hold_a), .stall_count(cnt_a)
  );

  // Narrow counter instance: all-ones is reached after a handful of stalls.
  hazard_ctrl_unit #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .ex_rd(ex_rd), .ex_reg_write_enable(ex_reg_write_enable),
    .ex_mem_to_reg_select(ex_mem_to_reg_select), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .pc_write_enable(pc_b), .if_id_write_enable(ifid_b), .if_id_flush(flush_b),
    .id_ex_bubble(bubble_b), .id_ex_hold(hold_b), .stall_count(cnt_b)
  );

  typedef struct {
    logic [3:0] rn, rm;
    logic       rn_used, rm_used;
    logic [3:0] rd;
    logic       we, ld, br, busy;
    logic [4:0] exp;   // {pc, if_id_we, flush, bubble, hold}
  } vec_t;

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_HOLD  = 5'b00001;
  localparam logic [4:0] O_RST   = 5'b00010;

  function automatic logic [4:0] outs_a();
    return {pc_a, ifid_a, flush_a, bubble_a, hold_a};
  endfunction

  function automatic logic [4:0] outs_b();
    return {pc_b, ifid_b, flush_b, bubble_b, hold_b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] rn, input logic [3:0] rm, input logic rnu,
                        input logic rmu, input logic [3:0] rd, input logic we,
                        input logic ld, input logic br, input logic busy);
    id_rn = rn; id_rm = rm; id_rn_used = rnu; id_rm_used = rmu; ex_rd = rd;
    ex_reg_write_enable = we; ex_mem_to_reg_select = ld;
    ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic idle();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[1]  = '{4'd3,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, O_STALL};
    vecs[2]  = '{4'd0,  4'd3, 1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, O_STALL};
    vecs[3]  = '{4'd0,  4'd3, 1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, O_RUN};
    vecs[4]  = '{4'd3,  4'd3, 1'b1, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[5]  = '{4'd3,  4'd3, 1'b1, 1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
    vecs[6]  = '{4'd4,  4'd2, 1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, O_RUN};
    vecs[7]  = '{4'd15, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, O_STALL};
    vecs[8]  = '{4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, O_FLUSH};
    vecs[9]  = '{4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, O_HOLD};
    vecs[10] = '{4'd3,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, O_HOLD};
    vecs[11] = '{4'd3,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, O_FLUSH};

    reset = 1'b0;
    idle();
    #2;
    chk("reset_outs", 32'(outs_a()), 32'(O_RST));
    chk("reset_outs_b", 32'(outs_b()), 32'(O_RST));
    chk("reset_count", 32'(cnt_a), 32'd0);
    #6 reset = 1'b1;

    // RUN-state decode: applied after the falling edge, cleared before the rising one.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(vecs[i].rn, vecs[i].rm, vecs[i].rn_used, vecs[i].rm_used, vecs[i].rd,
             vecs[i].we, vecs[i].ld, vecs[i].br, vecs[i].busy);
      #1;
      chk($sformatf("table_%0d", i), 32'(outs_a()), 32'(vecs[i].exp));
      #1 idle();
    end

    // Operand not read: no stall.
    cyc();
    set_in(4'd0, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("nostall_outs", 32'(outs_a()), 32'(O_RUN));
    cyc();
    chk("nostall_outs2", 32'(outs_a()), 32'(O_RUN));
    chk("nostall_count", 32'(cnt_a), 32'd0);

    // Load-use: one stall cycle, detection masked in LOAD_STALL.
    set_in(4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall", 32'(outs_a()), 32'(O_STALL));
    cyc();
    chk("lu_masked", 32'(outs_a()), 32'(O_RUN));
    chk("lu_count", 32'(cnt_a), 32'd1);
    chk("lu_count_b", 32'(cnt_b), 32'd1);
    idle();
    cyc();
    chk("lu_resume", 32'(outs_a()), 32'(O_RUN));
    chk("lu_count_hold", 32'(cnt_a), 32'd1);

    // Taken branch: three flush cycles at FLUSH_CYCLES=3, one at FLUSH_CYCLES=1.
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("br_flush1", 32'(outs_a()), 32'(O_FLUSH));
    chk("br_flush1_b", 32'(outs_b()), 32'(O_FLUSH));
    cyc();
    idle();
    #1 chk("br_flush2", 32'(outs_a()), 32'(O_FLUSH));
    chk("br_done_b", 32'(outs_b()), 32'(O_RUN));
    cyc();
    chk("br_flush3", 32'(outs_a()), 32'(O_FLUSH));
    cyc();
    chk("br_done", 32'(outs_a()), 32'(O_RUN));
    chk("br_count", 32'(cnt_a), 32'd1);

    // Memory wait for 4 cycles; load-use and branch in cycle 1 are outranked.
    set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk("mw_c1", 32'(outs_a()), 32'(O_HOLD));
    chk("mw_c1_b", 32'(outs_b()), 32'(O_HOLD));
    cyc();
    chk("sat_pre_b", 32'(cnt_b), 32'd2);
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("mw_c2", 32'(outs_a()), 32'(O_HOLD));
    cyc();
    chk("mw_c3", 32'(outs_a()), 32'(O_HOLD));
    cyc();
    chk("mw_c4", 32'(outs_a()), 32'(O_HOLD));
    cyc();
    idle();
    #1 chk("mw_release", 32'(outs_a()), 32'(O_RUN));
    chk("mw_count", 32'(cnt_a), 32'd5);
    chk("sat_count_b", 32'(cnt_b), 32'd3);
    cyc();
    chk("sat_nowrap_b", 32'(cnt_b), 32'd3);
    chk("mw_count_hold", 32'(cnt_a), 32'd5);

    // Reset during the second FLUSH-state cycle aborts the flush at once.
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    idle();
    cyc();
    reset = 1'b0;
    #1 chk("rst_async", 32'(outs_a()), 32'(O_RST));
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_count_b", 32'(cnt_b), 32'd0);
    #2 reset = 1'b1;
    cyc();
    chk("rst_run", 32'(outs_a()), 32'(O_RUN));
    cyc();
    chk("rst_no_residue", 32'(outs_a()), 32'(O_RUN));
    chk("rst_count_after", 32'(cnt_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
